branch_feedback_unit: RTL and testbench

Commit-side counterpart of the branch predictor. Takes each committed control-flow instruction from the ROB, compares the predicted next PC against the resolved next PC, queues a training record (index, taken, target) for the predictor and, on a mismatch, raises `jump_wrong` with the redirect PC and holds off further commits for a fixed flush window. Sits between ROB commit and the predictor/IF.

---
 rtl/branch_feedback_unit_pkg.sv | 19 +
 rtl/bfu_fifo.sv | 58 +++++
 rtl/branch_feedback_unit.sv | 134 +++++++++++++
 tb/tb_branch_feedback_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_feedback_unit_pkg.sv
// Shared widths, FSM state type and record-width helper for the branch feedback unit.
package branch_feedback_unit_pkg;

  localparam int BFU_PC_W        = 32;
  localparam int BFU_INDEX_W_DEF = 8;
  localparam int BFU_TAKEN_W     = 1;
  localparam logic [BFU_PC_W-1:0] BFU_INSN_BYTES = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bfu_state_e;

  // Training record layout is {index, taken, target}, MSB first.
  function automatic int bfu_rec_w(input int index_w);
    return index_w + BFU_TAKEN_W + BFU_PC_W;
  endfunction

endpackage

// File: rtl/bfu_fifo.sv
// Synchronous FIFO with a registered head entry; push when full and pop when empty are dropped.
// Extra pointer MSB separates full from empty; head updates on the same edge as the push/pop.
module bfu_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head_dat
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [PTR_W:0]   w_rd_inc;
  logic [PTR_W:0]   w_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty  = (r_wr_ptr == r_rd_ptr);
  assign o_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;
  assign w_rd_inc = r_rd_ptr + (PTR_W+1)'(1);
  assign w_count  = r_wr_ptr - r_rd_ptr;

  assign o_head_dat = r_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_dat;
        r_wr_ptr                   <= r_wr_ptr + (PTR_W+1)'(1);
      end
      if (w_pop) r_rd_ptr <= w_rd_inc;
      // Pushed entry becomes head when it is (or is about to be) the only one queued.
      if (w_push && (o_empty || (w_pop && w_count == (PTR_W+1)'(1))))
        r_head <= i_push_dat;
      else if (w_pop)
        r_head <= r_mem[w_rd_inc[PTR_W-1:0]];
    end
  end

endmodule

// File: rtl/branch_feedback_unit.sv
// Commit-side branch checker: queues predictor training records and pulses jump_wrong one cycle after a mispredicting commit.
// Commits blocked for FLUSH_CYCLES after a mispredict or when the queue is full; rdy=0 freezes all state. Stats under BFU_STATS_EN.
module branch_feedback_unit
  import branch_feedback_unit_pkg::*;
#(
  parameter int INDEX_W      = BFU_INDEX_W_DEF,
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                commit_valid,
  output logic                commit_ready,
  input  logic                commit_is_branch,
  input  logic                commit_real_jump,
  input  logic [BFU_PC_W-1:0] commit_pc,
  input  logic [BFU_PC_W-1:0] commit_target_pc,
  input  logic [BFU_PC_W-1:0] commit_pred_next_pc,
  output logic                fb_valid,
  input  logic                fb_ready,
  output logic [INDEX_W-1:0]  fb_index,
  output logic                fb_real_jump,
  output logic [BFU_PC_W-1:0] fb_target_pc,
  output logic                jump_wrong,
  output logic [BFU_PC_W-1:0] redirect_pc,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
);

  localparam int REC_W = bfu_rec_w(INDEX_W);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bfu_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_jump_wrong, w_jump_wrong_nxt;
  logic [BFU_PC_W-1:0] r_redirect_pc, w_redirect_nxt;

  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_branch_acc;
  logic                w_mispredict;
  logic                w_pop;
  logic [BFU_PC_W-1:0] w_actual_next;
  logic [REC_W-1:0]    w_push_rec;
  logic [REC_W-1:0]    w_head_rec;

  // rdy folds into ready and pop so nothing is handshaken while state is frozen.
  assign commit_ready  = rst && rdy && (r_state == ST_RUN) && !w_full;
  assign w_accept      = commit_valid && commit_ready;
  assign w_branch_acc  = w_accept && commit_is_branch;
  assign w_actual_next = commit_real_jump ? commit_target_pc : commit_pc + BFU_INSN_BYTES;
  assign w_mispredict  = w_branch_acc && (w_actual_next != commit_pred_next_pc);
  assign w_pop         = rdy && fb_ready && !w_empty;
  assign w_push_rec    = {commit_pc[INDEX_W+1:2], commit_real_jump, commit_target_pc};

  bfu_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_branch_acc),
    .i_push_dat (w_push_rec),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_dat (w_head_rec)
  );

  assign fb_valid = !w_empty;
  assign {fb_index, fb_real_jump, fb_target_pc} = w_head_rec;
  assign jump_wrong  = r_jump_wrong;
  assign redirect_pc = r_redirect_pc;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_jump_wrong_nxt = 1'b0;
    w_redirect_nxt   = r_redirect_pc;
    case (r_state)
      ST_RUN: begin
        if (w_mispredict) begin
          w_state_nxt      = ST_FLUSH;
          w_cnt_nxt        = CNT_W'(FLUSH_CYCLES - 1);
          w_jump_wrong_nxt = 1'b1;
          w_redirect_nxt   = w_actual_next;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == '0) w_state_nxt = ST_RUN;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_cnt         <= '0;
      r_jump_wrong  <= 1'b0;
      r_redirect_pc <= '0;
    end else if (rdy) begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_jump_wrong  <= w_jump_wrong_nxt;
      r_redirect_pc <= w_redirect_nxt;
    end
  end

`ifdef BFU_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_branch_acc) r_stat_branches    <= r_stat_branches + 32'd1;
      if (w_mispredict) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_feedback_unit.sv
// Scoreboard bench: stimulus pushes expected records/redirects at the accepting edge, a monitor pops them on handshakes.
module tb_branch_feedback_unit;

  localparam int INDEX_W = 8;
  localparam int DEPTH   = 4;
  localparam int FLUSH   = 2;

  typedef logic [INDEX_W+32:0] rec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               rdy;
  logic               commit_valid;
  logic               commit_ready;
  logic               commit_is_branch;
  logic               commit_real_jump;
  logic [31:0]        commit_pc;
  logic [31:0]        commit_target_pc;
  logic [31:0]        commit_pred_next_pc;
  logic               fb_valid;
  logic               fb_ready;
  logic [INDEX_W-1:0] fb_index;
  logic               fb_real_jump;
  logic [31:0]        fb_target_pc;
  logic               jump_wrong;
  logic [31:0]        redirect_pc;
  logic [31:0]        stat_branches;
  logic [31:0]        stat_mispredicts;

  branch_feedback_unit #(
    .INDEX_W      (INDEX_W),
    .FIFO_DEPTH   (DEPTH),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .commit_valid        (commit_valid),
    .commit_ready        (commit_ready),
    .commit_is_branch    (commit_is_branch),
    .commit_real_jump    (commit_real_jump),
    .commit_pc           (commit_pc),
    .commit_target_pc    (commit_target_pc),
    .commit_pred_next_pc (commit_pred_next_pc),
    .fb_valid            (fb_valid),
    .fb_ready            (fb_ready),
    .fb_index            (fb_index),
    .fb_real_jump        (fb_real_jump),
    .fb_target_pc        (fb_target_pc),
    .jump_wrong          (jump_wrong),
    .redirect_pc         (redirect_pc),
    .stat_branches       (stat_branches),
    .stat_mispredicts    (stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Reference model state
  rec_t        exp_fb[$];
  logic [31:0] exp_jw[$];
  int          occ;
  int          flush_left;
  logic [31:0] nbr;
  logic [31:0] nmis;
  bit          last_acc;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_fb.delete();
    exp_jw.delete();
    occ        = 0;
    flush_left = 0;
    nbr        = '0;
    nmis       = '0;
  endtask

  // One clock cycle; called and returns at posedge+1 so inputs are stable before the negedge.
  task automatic step();
    bit          exp_rdy, acc, pop;
    logic [31:0] actual;
    @(negedge clk);
    exp_rdy = rst && rdy && (flush_left == 0) && (occ < DEPTH);
    chk("commit_ready", commit_ready, exp_rdy);
`ifdef BFU_STATS_EN
    chk("stat_branches", stat_branches, nbr);
    chk("stat_mispredicts", stat_mispredicts, nmis);
`else
    chk("stat_branches", stat_branches, 0);
    chk("stat_mispredicts", stat_mispredicts, 0);
`endif
    acc      = commit_valid && exp_rdy;
    pop      = (occ > 0) && fb_ready && rdy && rst;
    last_acc = acc;
    @(posedge clk);
    if (rst) begin
      if (acc && commit_is_branch) begin
        actual = commit_real_jump ? commit_target_pc : commit_pc + 32'd4;
        exp_fb.push_back({commit_pc[INDEX_W+1:2], commit_real_jump, commit_target_pc});
        occ++;
        nbr++;
        if (actual != commit_pred_next_pc) begin
          exp_jw.push_back(actual);
          flush_left = FLUSH;
          nmis++;
        end else if (flush_left > 0 && rdy) flush_left--;
      end else if (flush_left > 0 && rdy) flush_left--;
      if (pop) occ--;
    end
    #1;
  endtask

  task automatic commit(input logic br, input logic rj, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic [31:0] pred);
    int n;
    commit_valid        = 1'b1;
    commit_is_branch    = br;
    commit_real_jump    = rj;
    commit_pc           = pc;
    commit_target_pc    = tgt;
    commit_pred_next_pc = pred;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 40);
    if (!last_acc) begin
      vectors++;
      miscompares++;
      $display("FAIL commit_accept_timeout: pc=%0h not accepted within 40 cycles", pc);
    end
    commit_valid = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_values();
    chk("rst_commit_ready", commit_ready, 0);
    chk("rst_fb_valid", fb_valid, 0);
    chk("rst_fb_index", fb_index, 0);
    chk("rst_fb_real_jump", fb_real_jump, 0);
    chk("rst_fb_target_pc", fb_target_pc, 0);
    chk("rst_jump_wrong", jump_wrong, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_stat_branches", stat_branches, 0);
    chk("rst_stat_mispredicts", stat_mispredicts, 0);
  endtask

  // Monitor: fb_valid/jump_wrong must track the scoreboard; handshakes pop and compare.
  initial begin
    rec_t        rec;
    logic [31:0] rpc;
    forever begin
      @(negedge clk);
      chk("fb_valid", fb_valid, exp_fb.size() != 0);
      if (fb_valid && fb_ready && rdy && exp_fb.size() != 0) begin
        rec = exp_fb.pop_front();
        chk("fb_record", {fb_index, fb_real_jump, fb_target_pc}, rec);
      end
      chk("jump_wrong", jump_wrong, exp_jw.size() != 0);
      if (jump_wrong && rdy && exp_jw.size() != 0) begin
        rpc = exp_jw.pop_front();
        chk("redirect_pc", redirect_pc, rpc);
      end
    end
  end

  initial begin
    logic [31:0] pc, tgt, act;
    rst = 1'b1;
    rdy = 1'b1;
    commit_valid = 1'b0;
    commit_is_branch = 1'b0;
    commit_real_jump = 1'b0;
    commit_pc = '0;
    commit_target_pc = '0;
    commit_pred_next_pc = '0;
    fb_ready = 1'b1;
    model_clear();
    #1 rst = 1'b0;
    #2 check_reset_values();
    @(posedge clk); #1;
    steps(2);
    rst = 1'b1;
    steps(1);

    // Correct not-taken branch, then taken mispredict, then wrong JALR target
    commit(1'b1, 1'b0, 32'h100, 32'hDEAD_0000, 32'h104);
    steps(3);
    commit(1'b1, 1'b1, 32'h200, 32'h180, 32'h204);
    steps(4);
    commit(1'b1, 1'b1, 32'h300, 32'h3F0, 32'h3E0);
    steps(4);
    // Non-branch commit never mispredicts or queues
    commit(1'b0, 1'b1, 32'h340, 32'h999C, 32'h0);
    steps(2);

    // Backpressure to full, single pop, drain
    fb_ready = 1'b0;
    for (int i = 0; i < 4; i++) commit(1'b1, i[0], 32'h400 + 32'(i*4), 32'h480 + 32'(i*4),
                                         i[0] ? 32'h480 + 32'(i*4) : 32'h404 + 32'(i*4));
    steps(2);
    fb_ready = 1'b1;
    steps(1);
    fb_ready = 1'b0;
    steps(2);
    fb_ready = 1'b1;
    steps(6);

    // rdy low during flush stretches it and holds the single pulse
    commit(1'b1, 1'b1, 32'h500, 32'h600, 32'h504);
    steps(1);
    rdy = 1'b0;
    steps(3);
    rdy = 1'b1;
    steps(5);

    // Reset mid-flush with two queued records
    fb_ready = 1'b0;
    commit(1'b1, 1'b0, 32'h700, 32'h0, 32'h704);
    commit(1'b1, 1'b1, 32'h800, 32'h900, 32'h804);
    steps(1);
    rst = 1'b0;
    model_clear();
    #1 check_reset_values();
    steps(2);
    rst = 1'b1;
    fb_ready = 1'b1;
    steps(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      pc  = ($urandom % 16 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      tgt = $urandom & 32'hFFFF_FFFC;
      commit_valid     = ($urandom % 4) != 0;
      commit_is_branch = ($urandom % 4) != 0;
      commit_real_jump = $urandom % 2;
      commit_pc        = pc;
      commit_target_pc = tgt;
      act = commit_real_jump ? tgt : pc + 32'd4;
      if ($urandom % 10 < 7)   commit_pred_next_pc = act;
      else if ($urandom % 2)   commit_pred_next_pc = pc + 32'd4;
      else                     commit_pred_next_pc = tgt ^ 32'h40;
      fb_ready = ($urandom % 3) != 0;
      rdy      = ($urandom % 10) != 0;
      step();
    end

    commit_valid = 1'b0;
    fb_ready = 1'b1;
    rdy = 1'b1;
    steps(20);
    chk("fb_queue_drained", exp_fb.size(), 0);
    chk("jump_wrong_drained", exp_jw.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
